// File: rtl/vga_top_800x600_60hz_down4x4.sv
// 800x600@60Hz VGA source with a 200x150 logical canvas (4x4 replication) and animated test pattern.
// Optional white border around the canvas is enabled by defining VGA_BORDER_EN.
module vga_top_800x600_60hz_down4x4 #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter bit          SYNC_POS   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [1:0] o_red,
  output logic [1:0] o_green,
  output logic [1:0] o_blue,
  output logic       o_hsync,
  output logic       o_vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);

`ifdef VGA_BORDER_EN
  localparam logic [10:0] PX_LAST = 11'((H_ACTIVE >> SCALE_LOG2) - 1);
  localparam logic [9:0]  PY_LAST = 10'((V_ACTIVE >> SCALE_LOG2) - 1);
`endif

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  red_q, red_d;
  logic [1:0]  green_q, green_d;
  logic [1:0]  blue_q, blue_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active;
  logic        border;

  always_comb begin
    h_cnt_d     = h_cnt_q + 11'd1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d     = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  // Logical pixel bits are taken straight from the counters, offset by the replication shift.
  always_comb begin
    active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
`ifdef VGA_BORDER_EN
    border = ((h_cnt_q >> SCALE_LOG2) == 11'd0) || ((h_cnt_q >> SCALE_LOG2) == PX_LAST) ||
             ((v_cnt_q >> SCALE_LOG2) == 10'd0) || ((v_cnt_q >> SCALE_LOG2) == PY_LAST);
`else
    border = 1'b0;
`endif
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      if (border) begin
        red_d   = 2'b11;
        green_d = 2'b11;
        blue_d  = 2'b11;
      end else begin
        red_d   = h_cnt_q[SCALE_LOG2 + 4 +: 2];
        green_d = v_cnt_q[SCALE_LOG2 + 4 +: 2];
        blue_d  = h_cnt_q[SCALE_LOG2 + 6 +: 2] ^ v_cnt_q[SCALE_LOG2 + 6 +: 2] ^ frame_cnt_q[5:4];
      end
    end
    hsync_d = ((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END)) ? SYNC_POS : ~SYNC_POS;
    vsync_d = ((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END)) ? SYNC_POS : ~SYNC_POS;
  end

  // Colour and sync share one register stage so they leave the chip aligned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hsync_q     <= ~SYNC_POS;
      vsync_q     <= ~SYNC_POS;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign o_red   = red_q;
  assign o_green = green_q;
  assign o_blue  = blue_q;
  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;

endmodule

// File: tb/tb_vga_top_800x600_60hz_down4x4.sv
// Bench for the VGA source: full-size instance for line timing and pattern, shrunken instance
// for frame timing and animation, both checked against an arithmetic position model.
`timescale 1ns/1ps
module tb_vga_top_800x600_60hz_down4x4;

  localparam int S_HA = 32, S_HFP = 4, S_HS = 8, S_HBP = 4;
  localparam int S_VA = 12, S_VFP = 1, S_VS = 4, S_VBP = 3;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_FRAME = S_HT * (S_VA + S_VFP + S_VS + S_VBP);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] redF, greenF, blueF, redS, greenS, blueS;
  logic hsF, vsF, hsS, vsS;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic inReset = 1'b1;

  always #12.5 clock = ~clock;

  vga_top_800x600_60hz_down4x4 dutFull (
    .i_clk(clock), .i_rst(reset), .o_red(redF), .o_green(greenF), .o_blue(blueF),
    .o_hsync(hsF), .o_vsync(vsF)
  );

  vga_top_800x600_60hz_down4x4 #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dutSmall (
    .i_clk(clock), .i_rst(reset), .o_red(redS), .o_green(greenS), .o_blue(blueS),
    .o_hsync(hsS), .o_vsync(vsS)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at n=%0d: got %0h, expected %0h", tag, n, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal);
    reset = rstVal;
    @(posedge clock);
    if (rstVal) begin
      inReset = 1'b1;
      n = 0;
    end else begin
      inReset = 1'b0;
      n++;
    end
    @(negedge clock);
  endtask

  // Pin values for a given number of pixel clocks since the counters were at (0,0) of frame 0.
  function automatic logic [7:0] modelPins(input int pos, input int ha, input int hfp, input int hs,
                                           input int hbp, input int va, input int vfp, input int vs,
                                           input int vbp);
    int ht, vt, h, v, frame, px, py;
    logic [1:0] r, g, b;
    logic hsync, vsync;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    h = pos % ht;
    v = (pos / ht) % vt;
    frame = (pos / (ht * vt)) % 256;
    px = h / 4;
    py = v / 4;
    r = 2'((px / 16) % 4);
    g = 2'((py / 16) % 4);
    b = 2'(((px / 64) % 4) ^ ((py / 64) % 4) ^ ((frame / 16) % 4));
`ifdef VGA_BORDER_EN
    if (px == 0 || px == ha / 4 - 1 || py == 0 || py == va / 4 - 1) begin
      r = 2'b11;
      g = 2'b11;
      b = 2'b11;
    end
`endif
    if (!(h < ha && v < va)) begin
      r = 2'b00;
      g = 2'b00;
      b = 2'b00;
    end
    hsync = (h >= ha + hfp) && (h < ha + hfp + hs);
    vsync = (v >= va + vfp) && (v < va + vfp + vs);
    return {r, g, b, hsync, vsync};
  endfunction

  initial begin
    int rstLen, midAt, midLen, p;
    int hsHigh, hsRise, hsPulses, vsHigh, vsRise, vsPulses;
    logic prevHs, prevVs;
    logic [5:0] colour64, rowRef;
    logic [1:0] blue0;
    logic [7:0] obsF, obsS, expF, expS;

    rstLen = $urandom_range(3, 6);
    midAt  = $urandom_range(2000, 6000);
    midLen = $urandom_range(1, 5);
    hsHigh = 0; hsRise = -1; hsPulses = 0; prevHs = 1'b0;
    vsHigh = 0; vsRise = -1; vsPulses = 0; prevVs = 1'b0;
    colour64 = '0; rowRef = '0; blue0 = '0;
    $display("[TB] reset %0d clocks, mid-frame reset at cycle %0d for %0d clocks", rstLen, midAt, midLen);

    for (int c = 0; c < 26000; c++) begin
      applyStimulus((c < rstLen) || (c >= midAt && c < midAt + midLen));
      obsF = {redF, greenF, blueF, hsF, vsF};
      obsS = {redS, greenS, blueS, hsS, vsS};
      if (inReset) begin
        checkOutput("fullResetPins", 32'(obsF), 32'h0);
        checkOutput("smallResetPins", 32'(obsS), 32'h0);
        hsHigh = 0; hsRise = -1; prevHs = 1'b0;
        vsHigh = 0; vsRise = -1; prevVs = 1'b0;
      end else begin
        p = n - 1;
        expF = modelPins(p, 800, 40, 128, 88, 600, 1, 4, 23);
        expS = modelPins(p, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP);
        checkOutput("fullPins", 32'(obsF), 32'(expF));
        checkOutput("smallPins", 32'(obsS), 32'(expS));

        if (hsF && !prevHs) begin
          if (hsRise >= 0) checkOutput("hsyncPeriod", 32'(n - hsRise), 32'd1056);
          hsRise = n;
        end
        if (hsF) hsHigh++;
        if (!hsF && prevHs) begin
          checkOutput("hsyncWidth", 32'(hsHigh), 32'd128);
          hsPulses++;
          hsHigh = 0;
        end
        prevHs = hsF;

        if (vsS && !prevVs) begin
          if (vsRise >= 0) checkOutput("vsyncPeriod", 32'(n - vsRise), 32'(S_FRAME));
          vsRise = n;
        end
        if (vsS) vsHigh++;
        if (!vsS && prevVs) begin
          checkOutput("vsyncWidth", 32'(vsHigh), 32'(S_VS * S_HT));
          vsPulses++;
          vsHigh = 0;
        end
        prevVs = vsS;

        if (p == 64) begin
`ifdef VGA_BORDER_EN
          checkOutput("px16Red", 32'(redF), 32'h3);
`else
          checkOutput("px16Red", 32'(redF), 32'h1);
`endif
          colour64 = obsF[7:2];
        end
        if (p >= 65 && p <= 67) checkOutput("hReplicate", 32'(obsF[7:2]), 32'(colour64));
        if (p == 4 * 1056 + 100) rowRef = obsF[7:2];
        if (p == 5 * 1056 + 100 || p == 6 * 1056 + 100 || p == 7 * 1056 + 100)
          checkOutput("vReplicate", 32'(obsF[7:2]), 32'(rowRef));

        if (p == 0) blue0 = blueS;
        if (p == 16 * S_FRAME) begin
`ifdef VGA_BORDER_EN
          checkOutput("animBlue", 32'(blueS ^ blue0), 32'h0);
`else
          checkOutput("animBlue", 32'(blueS ^ blue0), 32'h1);
`endif
        end
      end
    end

    checkOutput("hsyncSeen", 32'(hsPulses >= 8), 32'h1);
    checkOutput("vsyncSeen", 32'(vsPulses >= 15), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
